// File: rtl/ex_if.sv
// Decode-to-execute inputs and execute-to-mem outputs of the swt16 execute stage.
// master = decode/mem side (testbench), slave = the execute stage.
interface ex_if #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int ALU_OP_WIDTH    = 3
) ();
    logic [ALU_OP_WIDTH-1:0]    in_alu_op;
    logic [IALU_WORD_WIDTH-1:0] in_opa;
    logic [IALU_WORD_WIDTH-1:0] in_opb;
    logic [IALU_WORD_WIDTH-1:0] in_imm;
    logic                       in_act_load_dmem_word;
    logic                       in_act_load_dmem_byte_signed;
    logic                       in_act_load_dmem_byte_unsigned;
    logic                       in_act_store_dmem_byte;
    logic                       in_act_store_dmem_word;
    logic                       in_act_write_res_to_reg;
    logic [2:0]                 in_cycle_in_instr;
    logic [PMEM_WORD_WIDTH-1:0] in_instr;
    logic                       in_instr_is_bubble;
    logic [PC_WIDTH-1:0]        in_pc;
    logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx;

    logic                       out_stall;
    logic                       out_act_load_dmem_word;
    logic                       out_act_load_dmem_byte_signed;
    logic                       out_act_load_dmem_byte_unsigned;
    logic                       out_act_store_dmem_byte;
    logic                       out_act_store_dmem_word;
    logic                       out_act_write_res_to_reg;
    logic [2:0]                 out_cycle_in_instr;
    logic [PMEM_WORD_WIDTH-1:0] out_instr;
    logic                       out_instr_is_bubble;
    logic [PC_WIDTH-1:0]        out_pc;
    logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx;
    logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr;
    logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr;
    logic [IALU_WORD_WIDTH-1:0] out_mem_wr_word;
    logic [IALU_WORD_WIDTH-1:0] out_res;
    logic                       out_res_valid_MEM;

    modport master (
        output in_alu_op, in_opa, in_opb, in_imm,
               in_act_load_dmem_word, in_act_load_dmem_byte_signed, in_act_load_dmem_byte_unsigned,
               in_act_store_dmem_byte, in_act_store_dmem_word, in_act_write_res_to_reg,
               in_cycle_in_instr, in_instr, in_instr_is_bubble, in_pc, in_res_reg_idx,
        input  out_stall,
               out_act_load_dmem_word, out_act_load_dmem_byte_signed, out_act_load_dmem_byte_unsigned,
               out_act_store_dmem_byte, out_act_store_dmem_word, out_act_write_res_to_reg,
               out_cycle_in_instr, out_instr, out_instr_is_bubble, out_pc, out_res_reg_idx,
               out_mem_rd_addr, out_mem_wr_addr, out_mem_wr_word, out_res, out_res_valid_MEM
    );

    modport slave (
        input  in_alu_op, in_opa, in_opb, in_imm,
               in_act_load_dmem_word, in_act_load_dmem_byte_signed, in_act_load_dmem_byte_unsigned,
               in_act_store_dmem_byte, in_act_store_dmem_word, in_act_write_res_to_reg,
               in_cycle_in_instr, in_instr, in_instr_is_bubble, in_pc, in_res_reg_idx,
        output out_stall,
               out_act_load_dmem_word, out_act_load_dmem_byte_signed, out_act_load_dmem_byte_unsigned,
               out_act_store_dmem_byte, out_act_store_dmem_word, out_act_write_res_to_reg,
               out_cycle_in_instr, out_instr, out_instr_is_bubble, out_pc, out_res_reg_idx,
               out_mem_rd_addr, out_mem_wr_addr, out_mem_wr_word, out_res, out_res_valid_MEM
    );
endinterface

// File: rtl/ex.sv
// swt16 execute stage: ALU/address/store data registered to mem in 1 edge; MUL is iterative
// shift-add over IALU_WORD_WIDTH edges, holding decode with out_stall and sending bubbles to mem.
module ex #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int ALU_OP_WIDTH    = 3
) (
    input  logic clock,
    input  logic reset,
    ex_if.slave  bus
);
    localparam int W  = IALU_WORD_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHL = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHR = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_MUL = ALU_OP_WIDTH'(7);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    typedef struct packed {
        logic                       ld_word;
        logic                       ld_bs;
        logic                       ld_bu;
        logic                       st_byte;
        logic                       st_word;
        logic                       wr_reg;
        logic [2:0]                 cycle;
        logic [PMEM_WORD_WIDTH-1:0] instr;
        logic                       bubble;
        logic [PC_WIDTH-1:0]        pc;
        logic [REG_IDX_WIDTH-1:0]   rd;
        logic [DMEM_ADDR_WIDTH-1:0] addr;
        logic [W-1:0]               wr_word;
        logic [W-1:0]               res;
        logic                       res_vld;
    } stage_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    acc_q, acc_d;
    stage_t          lat_q, lat_d;
    stage_t          out_q, out_d;

    logic [W-1:0]    alu_res;
    logic [W-1:0]    addr_sum;
    logic [W-1:0]    acc_nx;
    stage_t          in_pkt;
    stage_t          bub_pkt;

    always_comb begin
        alu_res = '0;
        case (bus.in_alu_op)
            OP_ADD:  alu_res = bus.in_opa + bus.in_opb;
            OP_SUB:  alu_res = bus.in_opa - bus.in_opb;
            OP_AND:  alu_res = bus.in_opa & bus.in_opb;
            OP_OR:   alu_res = bus.in_opa | bus.in_opb;
            OP_XOR:  alu_res = bus.in_opa ^ bus.in_opb;
            OP_SHL:  alu_res = bus.in_opa << bus.in_opb[3:0];
            OP_SHR:  alu_res = bus.in_opa >> bus.in_opb[3:0];
            default: alu_res = '0;
        endcase
    end

    assign addr_sum = bus.in_opa + bus.in_imm;

    // Incoming slot as it would be registered; a bubble never carries an action.
    always_comb begin
        in_pkt         = '0;
        in_pkt.cycle   = bus.in_cycle_in_instr;
        in_pkt.instr   = bus.in_instr;
        in_pkt.bubble  = bus.in_instr_is_bubble;
        in_pkt.pc      = bus.in_pc;
        in_pkt.rd      = bus.in_res_reg_idx;
        in_pkt.addr    = addr_sum[DMEM_ADDR_WIDTH-1:0];
        in_pkt.wr_word = bus.in_opb;
        in_pkt.res     = alu_res;
        if (!bus.in_instr_is_bubble) begin
            in_pkt.ld_word = bus.in_act_load_dmem_word;
            in_pkt.ld_bs   = bus.in_act_load_dmem_byte_signed;
            in_pkt.ld_bu   = bus.in_act_load_dmem_byte_unsigned;
            in_pkt.st_byte = bus.in_act_store_dmem_byte;
            in_pkt.st_word = bus.in_act_store_dmem_word;
            in_pkt.wr_reg  = bus.in_act_write_res_to_reg;
            in_pkt.res_vld = bus.in_act_write_res_to_reg
                           & ~(bus.in_act_load_dmem_word
                             | bus.in_act_load_dmem_byte_signed
                             | bus.in_act_load_dmem_byte_unsigned);
        end
    end

    always_comb begin
        bub_pkt         = out_q;
        bub_pkt.bubble  = 1'b1;
        bub_pkt.ld_word = 1'b0;
        bub_pkt.ld_bs   = 1'b0;
        bub_pkt.ld_bu   = 1'b0;
        bub_pkt.st_byte = 1'b0;
        bub_pkt.st_word = 1'b0;
        bub_pkt.wr_reg  = 1'b0;
        bub_pkt.res_vld = 1'b0;
    end

    assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        lat_d    = lat_q;
        out_d    = out_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_alu_op == OP_MUL && !bus.in_instr_is_bubble) begin
                    lat_d    = in_pkt;
                    mcand_d  = bus.in_opa;
                    mplier_d = bus.in_opb;
                    acc_d    = '0;
                    cnt_d    = '0;
                    out_d    = bub_pkt;
                    state_d  = ST_MUL;
                end else begin
                    out_d = in_pkt;
                end
            end
            ST_MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last partial product folds straight into the emitted result.
                if (cnt_q == CW'(W - 1)) begin
                    out_d     = lat_q;
                    out_d.res = acc_nx;
                    state_d   = ST_IDLE;
                end else begin
                    out_d = bub_pkt;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            lat_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            lat_q    <= lat_d;
            out_q    <= out_d;
        end
    end

    assign bus.out_stall                       = (state_q == ST_MUL);
    assign bus.out_act_load_dmem_word          = out_q.ld_word;
    assign bus.out_act_load_dmem_byte_signed   = out_q.ld_bs;
    assign bus.out_act_load_dmem_byte_unsigned = out_q.ld_bu;
    assign bus.out_act_store_dmem_byte         = out_q.st_byte;
    assign bus.out_act_store_dmem_word         = out_q.st_word;
    assign bus.out_act_write_res_to_reg        = out_q.wr_reg;
    assign bus.out_cycle_in_instr              = out_q.cycle;
    assign bus.out_instr                       = out_q.instr;
    assign bus.out_instr_is_bubble             = out_q.bubble;
    assign bus.out_pc                          = out_q.pc;
    assign bus.out_res_reg_idx                 = out_q.rd;
    assign bus.out_mem_rd_addr                 = out_q.addr;
    assign bus.out_mem_wr_addr                 = out_q.addr;
    assign bus.out_mem_wr_word                 = out_q.wr_word;
    assign bus.out_res                         = out_q.res;
    assign bus.out_res_valid_MEM               = out_q.res_vld;
endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the swt16 execute stage.
module tb_ex;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_if bus ();

    ex dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] imm, input logic ld, input logic st,
                          input logic wr, input logic bub, input logic [3:0] rd);
        bus.in_alu_op                      = op;
        bus.in_opa                         = a;
        bus.in_opb                         = b;
        bus.in_imm                         = imm;
        bus.in_act_load_dmem_word          = ld;
        bus.in_act_load_dmem_byte_signed   = 1'b0;
        bus.in_act_load_dmem_byte_unsigned = 1'b0;
        bus.in_act_store_dmem_byte         = 1'b0;
        bus.in_act_store_dmem_word         = st;
        bus.in_act_write_res_to_reg        = wr;
        bus.in_cycle_in_instr              = 3'd1;
        bus.in_instr                       = a ^ 16'hA5A5;
        bus.in_instr_is_bubble             = bub;
        bus.in_pc                          = 12'h100;
        bus.in_res_reg_idx                 = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] acts();
        return {bus.out_act_load_dmem_word, bus.out_act_load_dmem_byte_signed,
                bus.out_act_load_dmem_byte_unsigned, bus.out_act_store_dmem_byte,
                bus.out_act_store_dmem_word, bus.out_act_write_res_to_reg, bus.out_res_valid_MEM};
    endfunction

    function automatic logic [99:0] all_out();
        return {bus.out_stall, acts(), bus.out_cycle_in_instr, bus.out_instr,
                bus.out_instr_is_bubble, bus.out_pc, bus.out_res_reg_idx, bus.out_mem_rd_addr,
                bus.out_mem_wr_addr, bus.out_mem_wr_word, bus.out_res};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            tick();
            checks++;
            if (all_out() !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", i, all_out());
            end
        end
        rst_n = 1'b1;
        set_in(3'd0, 16'd3, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        tick();
        checks++;
        if (bus.out_res !== 16'h0007 || bus.out_res_valid_MEM !== 1'b1) begin
            errors++;
            $display("FAIL add_after_reset: got res=%h vld=%b want 0007 1", bus.out_res, bus.out_res_valid_MEM);
        end
    endtask

    task automatic test_alu();
        logic [2:0]  ops  [4] = '{3'd1, 3'd5, 3'd6, 3'd4};
        logic [15:0] opa  [4] = '{16'h0000, 16'h8001, 16'h8000, 16'hF0F0};
        logic [15:0] opb  [4] = '{16'h0001, 16'h0011, 16'h0004, 16'hFFFF};
        logic [15:0] exp  [4] = '{16'hFFFF, 16'h0002, 16'h0800, 16'h0F0F};
        for (int i = 0; i < 4; i++) begin
            set_in(ops[i], opa[i], opb[i], 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
            tick();
            checks++;
            if (bus.out_res !== exp[i] || bus.out_mem_wr_word !== opb[i]) begin
                errors++;
                $display("FAIL alu_op%0d: got res=%h wr=%h want %h %h", ops[i], bus.out_res,
                         bus.out_mem_wr_word, exp[i], opb[i]);
            end
        end
    endtask

    task automatic test_load_addr();
        set_in(3'd0, 16'h0FFE, 16'h1234, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        tick();
        checks++;
        if (bus.out_mem_rd_addr !== 12'h001 || bus.out_mem_wr_addr !== 12'h001) begin
            errors++;
            $display("FAIL load_addr_wrap: got rd=%h wr=%h want 001", bus.out_mem_rd_addr, bus.out_mem_wr_addr);
        end
        checks++;
        if (bus.out_res_valid_MEM !== 1'b0 || bus.out_act_load_dmem_word !== 1'b1) begin
            errors++;
            $display("FAIL load_valid: got vld=%b ld=%b want 0 1", bus.out_res_valid_MEM, bus.out_act_load_dmem_word);
        end
    endtask

    task automatic test_bubble();
        set_in(3'd0, 16'h0010, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        tick();
        checks++;
        if (acts() !== 7'd0 || bus.out_instr_is_bubble !== 1'b1 || bus.out_res !== 16'h0030
            || bus.out_res_reg_idx !== 4'd7) begin
            errors++;
            $display("FAIL bubble: got acts=%b bub=%b res=%h rd=%0d want 0 1 0030 7",
                     acts(), bus.out_instr_is_bubble, bus.out_res, bus.out_res_reg_idx);
        end
    endtask

    task automatic test_mul();
        int n;
        int bad_bub;
        set_in(3'd7, 16'h0123, 16'h0045, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        tick();
        n = 0;
        bad_bub = 0;
        while (bus.out_stall === 1'b1 && n < 40) begin
            if (acts() !== 7'd0 || bus.out_instr_is_bubble !== 1'b1) bad_bub++;
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL mul_stall_len: got %0d want 16", n);
        end
        checks++;
        if (bad_bub !== 0) begin
            errors++;
            $display("FAIL mul_bubbles: got %0d bad bubbles want 0", bad_bub);
        end
        checks++;
        if (bus.out_res !== 16'h4E6F || bus.out_res_reg_idx !== 4'd5 || bus.out_res_valid_MEM !== 1'b1
            || bus.out_instr_is_bubble !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: got res=%h rd=%0d vld=%b bub=%b want 4e6f 5 1 0",
                     bus.out_res, bus.out_res_reg_idx, bus.out_res_valid_MEM, bus.out_instr_is_bubble);
        end
        set_in(3'd0, 16'h0100, 16'h0023, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        tick();
        checks++;
        if (bus.out_res !== 16'h0123 || bus.out_res_reg_idx !== 4'd6 || bus.out_stall !== 1'b0) begin
            errors++;
            $display("FAIL mul_next_add: got res=%h rd=%0d stall=%b want 0123 6 0",
                     bus.out_res, bus.out_res_reg_idx, bus.out_stall);
        end
    endtask

    task automatic test_mul_overflow();
        int n;
        set_in(3'd7, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
        tick();
        n = 0;
        while (bus.out_stall === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16 || bus.out_res !== 16'h0001) begin
            errors++;
            $display("FAIL mul_overflow: got n=%0d res=%h want 16 0001", n, bus.out_res);
        end
    endtask

    task automatic test_mul_reset();
        int seen;
        set_in(3'd7, 16'h0123, 16'h0045, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        tick();
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL mul_reset_async: got %h want 0", all_out());
        end
        tick();
        tick();
        set_in(3'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_res === 16'h4E6F || bus.out_res_valid_MEM !== 1'b0 || bus.out_stall !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mul_reset_no_result: got %0d bad cycles want 0", seen);
        end
        set_in(3'd0, 16'd5, 16'd6, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
        tick();
        checks++;
        if (bus.out_res !== 16'd11 || bus.out_res_valid_MEM !== 1'b1 || bus.out_res_reg_idx !== 4'd4) begin
            errors++;
            $display("FAIL mul_reset_next_add: got res=%h vld=%b rd=%0d want 000b 1 4",
                     bus.out_res, bus.out_res_valid_MEM, bus.out_res_reg_idx);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_in(3'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        test_reset();
        test_alu();
        test_load_addr();
        test_bubble();
        test_mul();
        test_mul_overflow();
        test_mul_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
